// File: rtl/idli_sqi_ctrl.sv
// SQI sequencer for the external quad SRAM: sends EQIO after reset, then runs CMD/ADDR/DUMMY/DATA bursts.
// Pins update one edge after the producing state; read slices appear two edges after sampling; o_wr_rdy paces write data.
module idli_sqi_ctrl #(
    parameter logic [7:0] CMD_RD   = 8'h03,
    parameter logic [7:0] CMD_WR   = 8'h02,
    parameter logic [7:0] CMD_EQIO = 8'h38
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    output logic        o_busy,
    output logic        o_wr_rdy,
    input  logic [3:0]  i_wr_data,
    output logic        o_rd_vld,
    output logic [3:0]  o_rd_data,
    output logic        o_done,
    output logic        o_sqi_cs,
    output logic        o_sqi_sck_en,
    output logic        o_sqi_oe,
    output logic [3:0]  o_sqi_sio,
    input  logic [3:0]  i_sqi_sio
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_INIT_END,
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_END
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;

    logic        cs_q, cs_d;
    logic        sck_en_q, sck_en_d;
    logic        oe_q, oe_d;
    logic [3:0]  sio_q, sio_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  smp_q, smp_d;
    logic        smp_vld_q, smp_vld_d;
    logic        rd_vld_q, rd_vld_d;
    logic [3:0]  rd_data_q, rd_data_d;

    logic [7:0]  cmd;
    logic [23:0] byte_addr;
    logic [23:0] addr_sh;

    assign cmd       = wr_q ? CMD_WR : CMD_RD;
    assign byte_addr = {7'b0, addr_q, 1'b0};
    assign addr_sh   = byte_addr << {cnt_q, 2'b00};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        cs_d      = 1'b1;
        sck_en_d  = 1'b0;
        oe_d      = 1'b0;
        sio_d     = 4'h0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        smp_d     = i_sqi_sio;
        smp_vld_d = 1'b0;
        rd_vld_d  = smp_vld_q;
        rd_data_d = smp_vld_q ? smp_q : rd_data_q;

        case (state_q)
            ST_INIT: begin
                // Still in SPI mode here: EQIO goes out one bit per clock on SIO0.
                cs_d     = 1'b0;
                sck_en_d = 1'b1;
                oe_d     = 1'b1;
                sio_d    = {3'b000, CMD_EQIO[3'd7 - cnt_q]};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_INIT_END;
                    cnt_d   = 3'd0;
                end
            end
            ST_INIT_END: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                busy_d = 1'b0;
                if (i_req) begin
                    wr_d    = i_wr;
                    addr_d  = i_addr;
                    cnt_d   = 3'd0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                cs_d     = 1'b0;
                sck_en_d = 1'b1;
                oe_d     = 1'b1;
                sio_d    = cnt_q[0] ? cmd[3:0] : cmd[7:4];
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q[0]) begin
                    state_d = ST_ADDR;
                    cnt_d   = 3'd0;
                end
            end
            ST_ADDR: begin
                cs_d     = 1'b0;
                sck_en_d = 1'b1;
                oe_d     = 1'b1;
                sio_d    = addr_sh[23:20];
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    state_d = wr_q ? ST_DATA : ST_DUMMY;
                    cnt_d   = 3'd0;
                end
            end
            ST_DUMMY: begin
                cs_d     = 1'b0;
                sck_en_d = 1'b1;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q[0]) begin
                    state_d = ST_DATA;
                    cnt_d   = 3'd0;
                end
            end
            ST_DATA: begin
                // The SRAM auto-increments, so further words just keep the burst going.
                cs_d      = 1'b0;
                sck_en_d  = 1'b1;
                oe_d      = wr_q;
                sio_d     = wr_q ? i_wr_data : 4'h0;
                smp_vld_d = ~wr_q;
                cnt_d     = {1'b0, cnt_q[1:0] + 2'd1};
                if (cnt_q[1:0] == 2'd3 && !i_req) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= 3'd0;
            wr_q      <= 1'b0;
            addr_q    <= 16'h0;
            cs_q      <= 1'b1;
            sck_en_q  <= 1'b0;
            oe_q      <= 1'b0;
            sio_q     <= 4'h0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            smp_q     <= 4'h0;
            smp_vld_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= 4'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            sck_en_q  <= sck_en_d;
            oe_q      <= oe_d;
            sio_q     <= sio_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            smp_q     <= smp_d;
            smp_vld_q <= smp_vld_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Combinational so the core sees the request a full cycle before the slice is launched.
    assign o_wr_rdy     = (state_q == ST_DATA) && wr_q;
    assign o_busy       = busy_q;
    assign o_rd_vld     = rd_vld_q;
    assign o_rd_data    = rd_data_q;
    assign o_done       = done_q;
    assign o_sqi_cs     = cs_q;
    assign o_sqi_sck_en = sck_en_q;
    assign o_sqi_oe     = oe_q;
    assign o_sqi_sio    = sio_q;

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// Bench for idli_sqi_ctrl: a behavioural quad SRAM on the pins doubles as the reference memory.
// Directed reset/read/write/multi-word/early-drop/reset-in-ADDR cases, then randomized transactions.
module tb_idli_sqi_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_req;
    logic        i_wr;
    logic [15:0] i_addr;
    logic        o_busy;
    logic        o_wr_rdy;
    logic [3:0]  i_wr_data;
    logic        o_rd_vld;
    logic [3:0]  o_rd_data;
    logic        o_done;
    logic        o_sqi_cs;
    logic        o_sqi_sck_en;
    logic        o_sqi_oe;
    logic [3:0]  o_sqi_sio;
    logic [3:0]  i_sqi_sio;

    idli_sqi_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_wr         (i_wr),
        .i_addr       (i_addr),
        .o_busy       (o_busy),
        .o_wr_rdy     (o_wr_rdy),
        .i_wr_data    (i_wr_data),
        .o_rd_vld     (o_rd_vld),
        .o_rd_data    (o_rd_data),
        .o_done       (o_done),
        .o_sqi_cs     (o_sqi_cs),
        .o_sqi_sck_en (o_sqi_sck_en),
        .o_sqi_oe     (o_sqi_oe),
        .o_sqi_sio    (o_sqi_sio),
        .i_sqi_sio    (i_sqi_sio)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [3:0]  mem [int];
    logic [3:0]  pins[$];
    logic [3:0]  rd_q[$];
    logic [3:0]  wq[$];
    logic [3:0]  wdat[$];
    int          bi = 0, spi_n = 0;
    int          oe_bad = 0, sck_bad = 0, done_n = 0, done_cyc = -1, wrrdy_n = 0;
    int          first_vld = -1, run = 0, max_run = 0;
    logic        quad = 1'b0;
    logic [7:0]  spi_sr = 8'h0, s_cmd = 8'h0;
    logic [23:0] s_addr = 24'h0;
    logic [31:0] last_hdr;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "bench timed out");
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int nmask(input int x);
        return x & 32'h3FFFF;
    endfunction

    function automatic int nidx(input logic [15:0] a, input int j);
        return nmask(int'(a) * 4 + j);
    endfunction

    // Unwritten locations hold a fixed address-derived pattern.
    function automatic logic [3:0] mem_rd(input int x);
        logic [17:0] a;
        a = 18'(nmask(x));
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {2'b00, a[17:16]} ^ 4'h6;
    endfunction

    // SRAM model plus pin/output recorder, all on the falling edge.
    always @(negedge i_clk) begin
        if (o_sqi_cs) begin
            bi        = 0;
            spi_n     = 0;
            i_sqi_sio = 4'($urandom);
        end else if (!quad) begin
            spi_sr = {spi_sr[6:0], o_sqi_sio[0]};
            spi_n++;
            if (spi_n == 8 && spi_sr == 8'h38) quad = 1'b1;
        end else begin
            pins.push_back(o_sqi_sio);
            if (!o_sqi_sck_en) sck_bad++;
            if (o_sqi_oe !== (bi < 8 || s_cmd == 8'h02)) oe_bad++;
            if (bi < 2) s_cmd = {s_cmd[3:0], o_sqi_sio};
            else if (bi < 8) s_addr = {s_addr[19:0], o_sqi_sio};
            else if (s_cmd == 8'h02) mem[nmask(int'(s_addr) * 2 + bi - 8)] = o_sqi_sio;
            if (s_cmd == 8'h03 && bi >= 9) i_sqi_sio = mem_rd(int'(s_addr) * 2 + bi - 9);
            else i_sqi_sio = 4'($urandom);
            bi++;
        end
        if (o_rd_vld) begin
            rd_q.push_back(o_rd_data);
            if (first_vld < 0) first_vld = cyc;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (o_done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (o_wr_rdy) begin
            wrrdy_n++;
            if (wq.size() != 0) i_wr_data = wq.pop_front();
            else i_wr_data = 4'($urandom);
        end else begin
            i_wr_data = 4'($urandom);
        end
    end

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 60 && o_busy; k++) begin
            @(negedge i_clk); #1;
        end
        chk_eq({tag, "_idle"}, o_busy, 0);
    endtask

    // Called just after reset is released; checks the EQIO preamble and the return to IDLE.
    task automatic chk_init(input string tag);
        logic [7:0] bits = 8'h0;
        int good = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk); #1;
            bits = {bits[6:0], o_sqi_sio[0]};
            if (!o_sqi_cs && o_sqi_sck_en && o_sqi_oe && o_sqi_sio[3:1] == 3'b000) good++;
        end
        chk_eq({tag, "_eqio_bits"}, bits, 8'h38);
        chk_eq({tag, "_eqio_pins"}, good, 8);
        @(negedge i_clk); #1;
        chk_eq({tag, "_csh_cs"}, o_sqi_cs, 1);
        chk_eq({tag, "_csh_busy"}, o_busy, 1);
        @(negedge i_clk); #1;
        chk_eq({tag, "_busy_fall"}, o_busy, 0);
    endtask

    task automatic verify(input string tag, input bit wr, input logic [15:0] addr, input int nw, input int e0);
        logic [31:0] hdr = 32'h0;
        for (int j = 0; j < 8 && j < pins.size(); j++) hdr = {hdr[27:0], pins[j]};
        last_hdr = hdr;
        chk_eq({tag, "_hdr"}, hdr, {(wr ? 8'h02 : 8'h03), 7'b0, addr, 1'b0});
        chk_eq({tag, "_cs_cycles"}, pins.size(), (wr ? 8 : 10) + 4 * nw);
        chk_eq({tag, "_pin_ctl"}, oe_bad + sck_bad, 0);
        chk_eq({tag, "_done_n"}, done_n, 1);
        chk_eq({tag, "_done_cyc"}, done_cyc - e0, (wr ? 13 : 15) + 4 * (nw - 1));
        if (wr) begin
            chk_eq({tag, "_wrrdy_n"}, wrrdy_n, 4 * nw);
            chk_eq({tag, "_no_rdvld"}, rd_q.size(), 0);
            for (int j = 0; j < 4 * nw; j++)
                chk_eq($sformatf("%s_wmem%0d", tag, j), mem_rd(nidx(addr, j)), wdat[j]);
        end else begin
            chk_eq({tag, "_rd_n"}, rd_q.size(), 4 * nw);
            chk_eq({tag, "_first_vld"}, first_vld - e0, 12);
            chk_eq({tag, "_vld_run"}, max_run, 4 * nw);
            chk_eq({tag, "_no_wrrdy"}, wrrdy_n, 0);
            for (int j = 0; j < 4 * nw && j < rd_q.size(); j++)
                chk_eq($sformatf("%s_rd%0d", tag, j), rd_q[j], mem_rd(nidx(addr, j)));
        end
    endtask

    task automatic run_txn(input string tag, input bit wr, input logic [15:0] addr,
                           input int nw, input int drop_c);
        int e0;
        bit seen = 1'b0;
        wait_idle(tag);
        pins.delete();
        rd_q.delete();
        oe_bad = 0; sck_bad = 0; done_n = 0; done_cyc = -1; wrrdy_n = 0;
        first_vld = -1; run = 0; max_run = 0;
        wq = wdat;
        i_wr = wr; i_addr = addr; i_req = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk); #1;
        e0 = cyc;
        for (int k = 0; k < 120 && !seen; k++) begin
            if (cyc - e0 >= drop_c) i_req = 1'b0;
            if (done_n != 0) seen = 1'b1;
            else begin
                @(negedge i_clk); #1;
            end
        end
        i_req = 1'b0;
        chk_eq({tag, "_done_seen"}, seen, 1);
        repeat (3) begin
            @(negedge i_clk); #1;
        end
        verify(tag, wr, addr, nw, e0);
    endtask

    logic [3:0] rd_pat [4];
    logic [15:0] pk;
    int e0r;

    initial begin
        i_rst = 1'b1; i_req = 1'b0; i_wr = 1'b0; i_addr = 16'h0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk); #1;
        chk_eq("rst_cs", o_sqi_cs, 1);
        chk_eq("rst_sck_en", o_sqi_sck_en, 0);
        chk_eq("rst_oe", o_sqi_oe, 0);
        chk_eq("rst_sio", o_sqi_sio, 0);
        chk_eq("rst_busy", o_busy, 1);
        chk_eq("rst_rd_vld", o_rd_vld, 0);
        chk_eq("rst_rd_data", o_rd_data, 0);
        chk_eq("rst_done", o_done, 0);
        chk_eq("rst_wr_rdy", o_wr_rdy, 0);
        i_rst = 1'b0;
        chk_init("init");

        rd_pat[0] = 4'h5; rd_pat[1] = 4'hA; rd_pat[2] = 4'hF; rd_pat[3] = 4'h0;
        for (int j = 0; j < 4; j++) mem[nidx(16'h1234, j)] = rd_pat[j];
        wdat.delete();
        run_txn("rd1234", 1'b0, 16'h1234, 1, 13);
        chk_eq("rd1234_pins", last_hdr, 32'h03002468);
        pk = 16'h0;
        for (int j = 0; j < 4 && j < rd_q.size(); j++) pk = {pk[11:0], rd_q[j]};
        chk_eq("rd1234_data", pk, 16'h5AF0);

        wdat = '{4'h1, 4'h2, 4'h3, 4'h4};
        run_txn("wrFFFF", 1'b1, 16'hFFFF, 1, 11);
        chk_eq("wrFFFF_pins", last_hdr, 32'h0201FFFE);
        pk = 16'h0;
        for (int j = 8; j < 12 && j < pins.size(); j++) pk = {pk[11:0], pins[j]};
        chk_eq("wrFFFF_data_pins", pk, 16'h1234);

        wdat.delete();
        run_txn("rd3w", 1'b0, 16'h0040, 3, 21);
        run_txn("rddrop", 1'b0, 16'h0200, 1, 11);

        // Reset landing in the middle of the address phase.
        wait_idle("rstaddr");
        i_wr = 1'b0; i_addr = 16'h0ABC; i_req = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk); #1;
        e0r = cyc;
        repeat (4) begin
            @(negedge i_clk); #1;
        end
        chk_eq("rstaddr_in_burst", o_sqi_cs, 0);
        chk_eq("rstaddr_cyc", cyc - e0r, 4);
        i_rst = 1'b1; i_req = 1'b0;
        @(negedge i_clk); #1;
        chk_eq("rstaddr_cs", o_sqi_cs, 1);
        chk_eq("rstaddr_oe", o_sqi_oe, 0);
        chk_eq("rstaddr_busy", o_busy, 1);
        chk_eq("rstaddr_sck_en", o_sqi_sck_en, 0);
        i_rst = 1'b0;
        chk_init("reinit");

        for (int t = 0; t < 24; t++) begin
            bit          rw;
            logic [15:0] ra;
            int          rn;
            rw = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 1) != 0) ? 16'h0300 + 16'($urandom_range(0, 7)) : 16'($urandom);
            rn = $urandom_range(1, 3);
            wdat.delete();
            if (rw) for (int j = 0; j < 4 * rn; j++) wdat.push_back(4'($urandom));
            run_txn($sformatf("rnd%0d", t), rw, ra, rn, (rw ? 11 : 13) + 4 * (rn - 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idli_sqi_ctrl.md
# idli_sqi_ctrl

Sequences the core's SQI (serial quad I/O) port to the external 23LC1024-class SRAM that backs all program and data memory. On reset it switches the SRAM from SPI to quad mode. It then turns core read and write requests into command, address, dummy and data phases on the four SIO pins. Data moves one 4b slice per cycle, in the same slice order the core's serial datapath uses, so that the SRC_SQI and DST_SQI operand paths can stream directly.

## Interface
Parameters:
- CMD_RD, 8'h03, quad-mode read command.
- CMD_WR, 8'h02, quad-mode write command.
- CMD_EQIO, 8'h38, enter-quad-I/O command, sent once after reset in SPI mode.

Ports:
- i_clk  in  1  core clock; the sole clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_req  in  1  transaction request; held high for as long as further words are wanted.
- i_wr  in  1  1 = write, 0 = read; sampled with i_req in IDLE.
- i_addr  in  16  word address; sampled with i_req in IDLE.
- o_busy  out  1  controller is not in IDLE.
- o_wr_rdy  out  1  core must present the next write slice on i_wr_data this cycle.
- i_wr_data  in  4  write slice (slice_t).
- o_rd_vld  out  1  o_rd_data holds a valid read slice this cycle.
- o_rd_data  out  4  read slice (slice_t).
- o_done  out  1  one-cycle pulse when a transaction ends.
- o_sqi_cs  out  1  SRAM chip select, active-low at the pin (1 = deselected).
- o_sqi_sck_en  out  1  SCK gate enable; pad logic drives SCK = ~i_clk while enabled.
- o_sqi_oe  out  1  drive enable for SIO[3:0].
- o_sqi_sio  out  4  SIO output nibble.
- i_sqi_sio  in  4  SIO input nibble.

## Operation
- All outputs are registered except o_wr_rdy, which decodes state.
- Reset values: o_sqi_cs=1, o_sqi_sck_en=0, o_sqi_oe=0, o_sqi_sio=0, o_busy=1, o_rd_vld=0, o_rd_data=0, o_done=0, o_wr_rdy=0. After reset the controller enters INIT.
- States: INIT, INIT_END, IDLE, CMD, ADDR, DUMMY, DATA, END.
- INIT: 8 cycles with cs low, sck_en=1, oe=1, and CMD_EQIO sent MSB first on sio[0]; sio[3:1]=0. Requests are ignored.
- INIT_END: 1 cycle with cs high, then IDLE.
- IDLE:
  - o_busy=0.
  - When i_req=1, latch i_wr and i_addr and go to CMD.
- CMD: 2 cycles, command high nibble then low nibble; oe=1.
- ADDR: 6 cycles carrying the 24b byte address {7'b0, addr, 1'b0}, MSB nibble first.
- DUMMY (read only): 2 cycles with oe=0; sck_en stays 1.
- DATA: slices are transferred slice 0 first, 4 per word. The memory image is stored in this order.
  - Write: oe=1. o_wr_rdy is high one cycle before each slice goes on the pins (from the last ADDR cycle onward). i_wr_data is registered onto o_sqi_sio at the next edge.
  - Read: oe=0. i_sqi_sio is sampled every DATA cycle and presented on o_rd_data with o_rd_vld=1 on the following cycle.
  - A 2b slice counter runs in DATA. At slice 3, i_req is sampled: 1 continues with the next word (the SRAM auto-increments the address); 0 goes to END.
- END: 1 cycle with cs high, sck_en=0, oe=0, o_done=1, then IDLE. This gives the SRAM its minimum CS-high time.
- Reset asserted in any state takes effect at the next edge: all outputs return to reset values and INIT is re-run. The SRAM is re-sent EQIO; the command is harmless if the SRAM is already in quad mode.
- Dropping i_req in the middle of a word has no effect until slice 3.

## Timing
- Let E0 be the edge at which i_req=1 is sampled in IDLE.
- Edges E1–E2 launch CMD; E3–E8 launch ADDR.
- Read:
  - Edges E9–E10 are DUMMY.
  - DATA slice k is sampled at edge E11+k.
  - o_rd_vld is high in the cycles after E12 onward: first slice after 12 cycles.
  - A 1-word read completes with o_done in the cycle after E15, then IDLE after E16.
- Write:
  - o_wr_rdy is high in the cycles after E8 through E11 for word 0.
  - Slice k is on the pins after edge E9+k.
  - A 1-word write shows o_done in the cycle after E13.
- Back-to-back: a request held through END is accepted at the first IDLE edge, so there is at least 1 CS-high cycle plus 1 IDLE cycle between transactions.
- Throughput: 1 slice per cycle during DATA; no bubbles between consecutive words.

## Test plan
- Reset, then idle: o_sqi_sio[0] carries bits 0,0,1,1,1,0,0,0 over 8 cycles with cs low. cs then goes high for 1 cycle. o_busy falls 10 cycles after reset release.
- Read with i_addr=16'h1234: the pins show nibbles 0,3,0,0,2,4,6,8, then 2 dummy cycles. SRAM model returns 5,A,F,0, so o_rd_data is 5,A,F,0 with o_rd_vld on consecutive cycles and a single o_done.
- Write with i_addr=16'hFFFF, data slices 1,2,3,4: the pins show 0,2,0,1,F,F,F,E,1,2,3,4. o_wr_rdy is high for exactly 4 cycles. There is no DUMMY phase.
- i_req held for 3 words of a read: 12 contiguous o_rd_vld cycles, one CMD/ADDR phase, one o_done.
- i_req dropped at slice 1: the transfer still completes 4 slices and then ends.
- Reset asserted during ADDR: next cycle cs=1, oe=0, o_busy=1, and INIT restarts.
